// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the two requester ports, the shared memory port
// and the mux select of mem_port_arbiter.
//   a_* / b_*  : requester handshake (req/we/addr/wdata in, gnt/rvalid/rdata/err out)
//   mem_*      : shared memory port (req/we/addr/wdata out, ack/rdata in)
//   sel        : owner of the port, control input of the downstream 2:1 mux
// Modports: master = arbiter side, slave = environment side.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_gnt;
   logic              a_rvalid;
   logic [DATA_W-1:0] a_rdata;
   logic              a_err;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_gnt;
   logic              b_rvalid;
   logic [DATA_W-1:0] b_rdata;
   logic              b_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   logic              sel;

   modport master (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata, a_err,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_rvalid, b_rdata, b_err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output sel
   );

   modport slave (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata, a_err,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_rvalid, b_rdata, b_err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  sel
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between requester A (instruction
// fetch) and requester B (load/store). Round-robin, one transaction
// outstanding, hung accesses aborted after TIMEOUT_CYC busy cycles with err.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.master (requester ports, memory port, sel)
// All outputs are registered.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.master   bus
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;     // 0 = A, 1 = B served last
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic              a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
   logic              a_rv_q, a_rv_d, b_rv_q, b_rv_d;
   logic              a_err_q, a_err_d, b_err_q, b_err_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic              mreq_q, mreq_d, mwe_q, mwe_d;
   logic [ADDR_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] mwdata_q, mwdata_d;

   logic              grant_a, grant_b;
   logic              finish, timed_out;
   logic [DATA_W-1:0] ret_data;

   // Tie goes to the requester that was not served last.
   assign grant_a = bus.a_req & (~bus.b_req | last_q);
   assign grant_b = bus.b_req & (~bus.a_req | ~last_q);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      a_gnt_d   = 1'b0;
      b_gnt_d   = 1'b0;
      a_rv_d    = 1'b0;
      b_rv_d    = 1'b0;
      a_err_d   = 1'b0;
      b_err_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      mreq_d    = mreq_q;
      mwe_d     = mwe_q;
      maddr_d   = maddr_q;
      mwdata_d  = mwdata_q;
      finish    = 1'b0;
      timed_out = 1'b0;
      ret_data  = '0;

      unique case (state_q)
         IDLE: begin
            if (grant_a) begin
               a_gnt_d  = 1'b1;
               sel_d    = 1'b0;
               mreq_d   = 1'b1;
               mwe_d    = bus.a_we;
               maddr_d  = bus.a_addr;
               mwdata_d = bus.a_wdata;
               cnt_d    = '0;
               state_d  = BUSY;
            end else if (grant_b) begin
               b_gnt_d  = 1'b1;
               sel_d    = 1'b1;
               mreq_d   = 1'b1;
               mwe_d    = bus.b_we;
               maddr_d  = bus.b_addr;
               mwdata_d = bus.b_wdata;
               cnt_d    = '0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            // An ack on the threshold cycle still wins over the timeout.
            if (bus.mem_ack) begin
               finish   = 1'b1;
               ret_data = mwe_q ? '0 : bus.mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               finish    = 1'b1;
               timed_out = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         mreq_d  = 1'b0;
         last_d  = sel_q;
         state_d = IDLE;
         if (sel_q) begin
            b_rv_d    = 1'b1;
            b_err_d   = timed_out;
            b_rdata_d = ret_data;
         end else begin
            a_rv_d    = 1'b1;
            a_err_d   = timed_out;
            a_rdata_d = ret_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         sel_q     <= 1'b0;
         a_gnt_q   <= 1'b0;
         b_gnt_q   <= 1'b0;
         a_rv_q    <= 1'b0;
         b_rv_q    <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         mreq_q    <= 1'b0;
         mwe_q     <= 1'b0;
         maddr_q   <= '0;
         mwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         a_gnt_q   <= a_gnt_d;
         b_gnt_q   <= b_gnt_d;
         a_rv_q    <= a_rv_d;
         b_rv_q    <= b_rv_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         mreq_q    <= mreq_d;
         mwe_q     <= mwe_d;
         maddr_q   <= maddr_d;
         mwdata_q  <= mwdata_d;
      end
   end

   assign bus.a_gnt     = a_gnt_q;
   assign bus.a_rvalid  = a_rv_q;
   assign bus.a_rdata   = a_rdata_q;
   assign bus.a_err     = a_err_q;
   assign bus.b_gnt     = b_gnt_q;
   assign bus.b_rvalid  = b_rv_q;
   assign bus.b_rdata   = b_rdata_q;
   assign bus.b_err     = b_err_q;
   assign bus.mem_req   = mreq_q;
   assign bus.mem_we    = mwe_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.mem_wdata = mwdata_q;
   assign bus.sel       = sel_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus for mem_port_arbiter with a
// transaction-level reference model checked every cycle, plus literal
// expectations at key points of each scenario.
module tb_mem_port_arbiter;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // owner: -1 = port free, 0 = A, 1 = B; age = busy cycles elapsed.
   int          m_owner = -1;
   int          m_age   = 0;
   int          m_last  = 1;
   bit          m_valid = 1'b0;
   logic [1:0]  e_gnt  = '0;
   logic [1:0]  e_rv   = '0;
   logic [1:0]  e_err  = '0;
   logic [31:0] e_rdata [2];
   logic        e_mem_req = 1'b0;
   logic        e_we  = 1'b0;
   logic        e_sel = 1'b0;
   logic [31:0] e_addr  = '0;
   logic [31:0] e_wdata = '0;

   always @(posedge clk) begin
      int w;
      e_gnt = '0;
      e_rv  = '0;
      e_err = '0;
      if (rst) begin
         m_owner = -1; m_age = 0; m_last = 1;
         e_mem_req = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
         e_rdata[0] = 0; e_rdata[1] = 0;
         m_valid = 1'b1;
      end else if (m_owner < 0) begin
         w = -1;
         if (bus.a_req && bus.b_req) w = 1 - m_last;
         else if (bus.a_req)         w = 0;
         else if (bus.b_req)         w = 1;
         if (w >= 0) begin
            m_owner   = w;
            m_age     = 0;
            e_gnt[w]  = 1'b1;
            e_sel     = (w == 1);
            e_mem_req = 1'b1;
            e_we      = (w == 1) ? bus.b_we    : bus.a_we;
            e_addr    = (w == 1) ? bus.b_addr  : bus.a_addr;
            e_wdata   = (w == 1) ? bus.b_wdata : bus.a_wdata;
         end
      end else begin
         m_age++;
         if (bus.mem_ack || m_age == int'(TO)) begin
            e_rv[m_owner]    = 1'b1;
            e_err[m_owner]   = !bus.mem_ack;
            e_rdata[m_owner] = (bus.mem_ack && !e_we) ? bus.mem_rdata : 32'h0;
            m_last    = m_owner;
            m_owner   = -1;
            e_mem_req = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("a_gnt",    bus.a_gnt,    e_gnt[0]);
         chk("b_gnt",    bus.b_gnt,    e_gnt[1]);
         chk("a_rvalid", bus.a_rvalid, e_rv[0]);
         chk("b_rvalid", bus.b_rvalid, e_rv[1]);
         chk("a_err",    bus.a_err,    e_err[0]);
         chk("b_err",    bus.b_err,    e_err[1]);
         chk("mem_req",  bus.mem_req,  e_mem_req);
         chk("sel",      bus.sel,      e_sel);
         if (e_mem_req) begin
            chk("mem_we",    bus.mem_we,    e_we);
            chk("mem_addr",  bus.mem_addr,  e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wdata);
         end
         if (e_rv[0]) chk("a_rdata", bus.a_rdata, e_rdata[0]);
         if (e_rv[1]) chk("b_rdata", bus.b_rdata, e_rdata[1]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_gnt(input string name);
      int n;
      n = 0;
      do begin
         tick;
         n++;
      end while (!(bus.a_gnt || bus.b_gnt) && n < 20);
      chk({name, "_gnt_seen"}, bus.a_gnt | bus.b_gnt, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int gcyc[$];
      int gwho[$];
      bit prev;
      int nreq;
      int k;

      rst = 1'b1;
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
      bus.mem_ack = 0; bus.mem_rdata = 0;

      // 1. reset with both requesting; A wins the first tie
      tick; tick;
      chk("rst_a_gnt",   bus.a_gnt, 0);
      chk("rst_b_gnt",   bus.b_gnt, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_sel",     bus.sel, 0);
      chk("rst_a_rdata", bus.a_rdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      rst = 1'b0;
      wait_gnt("t1");
      chk("t1_a_gnt", bus.a_gnt, 1);
      chk("t1_b_gnt", bus.b_gnt, 0);
      chk("t1_sel",   bus.sel, 0);
      // B drops before being granted; A acked in its first busy cycle
      bus.a_req = 0; bus.b_req = 0;
      bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD_F00D;
      tick;
      bus.mem_ack = 0;
      chk("t1_a_rvalid", bus.a_rvalid, 1);
      chk("t1_a_rdata",  bus.a_rdata, 32'h0BAD_F00D);
      tick; tick;
      chk("t1_no_b_gnt", bus.b_gnt, 0);

      // 2. A read, ack two cycles after mem_req
      bus.a_req = 1; bus.a_addr = 32'h100;
      wait_gnt("t2");
      chk("t2_a_gnt", bus.a_gnt, 1);
      bus.a_req = 0; bus.a_addr = 0;
      tick;
      chk("t2_mem_addr", bus.mem_addr, 32'h100);
      tick;
      bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF;
      tick;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      chk("t2_a_rvalid", bus.a_rvalid, 1);
      chk("t2_a_rdata",  bus.a_rdata, 32'hDEAD_BEEF);
      chk("t2_a_err",    bus.a_err, 0);
      chk("t2_mem_req",  bus.mem_req, 0);
      tick;

      // 4. B write; port values held while inputs change
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 32'h2000; bus.b_wdata = 32'h1234_5678;
      wait_gnt("t4");
      chk("t4_b_gnt", bus.b_gnt, 1);
      chk("t4_sel",   bus.sel, 1);
      bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
      for (int i = 0; i < 2; i++) begin
         chk("t4_mem_we",    bus.mem_we, 1);
         chk("t4_mem_addr",  bus.mem_addr, 32'h2000);
         chk("t4_mem_wdata", bus.mem_wdata, 32'h1234_5678);
         tick;
      end
      bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
      tick;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      chk("t4_b_rvalid", bus.b_rvalid, 1);
      chk("t4_b_rdata",  bus.b_rdata, 0);
      chk("t4_b_err",    bus.b_err, 0);
      tick;

      // 3. contention; memory acks one cycle after seeing mem_req
      bus.a_req = 1; bus.b_req = 1;
      prev = 0;
      for (int c = 1; c <= 12; c++) begin
         tick;
         if (bus.a_gnt) begin gcyc.push_back(c); gwho.push_back(0); chk("t3_sel_a", bus.sel, 0); end
         if (bus.b_gnt) begin gcyc.push_back(c); gwho.push_back(1); chk("t3_sel_b", bus.sel, 1); end
         bus.mem_ack = bus.mem_req && prev;
         prev = bus.mem_req;
      end
      bus.a_req = 0; bus.b_req = 0; bus.mem_ack = 0;
      chk("t3_grant_count", gcyc.size(), 4);
      for (int i = 0; i < gcyc.size(); i++) begin
         chk("t3_grant_order", gwho[i], i % 2);
         if (i > 0) chk("t3_grant_gap", gcyc[i] - gcyc[i-1], 3);
      end
      tick; tick;

      // 5a. ack on the timeout threshold cycle is a normal completion
      bus.b_req = 1;
      wait_gnt("t5a");
      bus.b_req = 0;
      tick; tick; tick;
      chk("t5a_mem_req", bus.mem_req, 1);
      bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_0001;
      tick;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      chk("t5a_b_rvalid", bus.b_rvalid, 1);
      chk("t5a_b_err",    bus.b_err, 0);
      chk("t5a_b_rdata",  bus.b_rdata, 32'hCAFE_0001);
      tick;

      // 5. timeout, then a stray ack in IDLE
      bus.a_req = 1; bus.a_addr = 32'h300;
      wait_gnt("t5");
      bus.a_req = 0;
      nreq = bus.mem_req ? 1 : 0;
      k = 0;
      while (!bus.a_rvalid && k < 20) begin
         tick;
         k++;
         if (bus.mem_req) nreq++;
      end
      chk("t5_a_rvalid", bus.a_rvalid, 1);
      chk("t5_req_cycles", nreq, 4);
      chk("t5_a_err",    bus.a_err, 1);
      chk("t5_a_rdata",  bus.a_rdata, 0);
      bus.mem_ack = 1; bus.mem_rdata = 32'h55;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("t5_idle_ack_a", bus.a_rvalid, 0);
         chk("t5_idle_ack_req", bus.mem_req, 0);
      end
      bus.mem_ack = 0; bus.mem_rdata = 0;

      // 6. reset while B owns the port; A last served, but reset restores last=B
      bus.b_req = 1;
      wait_gnt("t6");
      chk("t6_b_gnt", bus.b_gnt, 1);
      bus.b_req = 0;
      tick;
      rst = 1'b1;
      tick;
      chk("t6_mem_req",  bus.mem_req, 0);
      chk("t6_b_rvalid", bus.b_rvalid, 0);
      chk("t6_b_err",    bus.b_err, 0);
      chk("t6_sel",      bus.sel, 0);
      rst = 1'b0;
      bus.a_req = 1; bus.b_req = 1;
      wait_gnt("t6_tie");
      chk("t6_tie_a", bus.a_gnt, 1);
      chk("t6_tie_b", bus.b_gnt, 0);
      bus.a_req = 0; bus.b_req = 0;
      bus.mem_ack = 1;
      tick;
      bus.mem_ack = 0;
      tick; tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
